mdu_core: RTL and testbench
===========================

// Module: mdu_core
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
//   Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds results in HI/LO for MFHI/MFLO.
//   Sits in the EX stage beside the ALU. The hazard unit stalls on busy; CP0 req suppresses issue on exception.
// PARAMETERS
//   WIDTH        32  operand and HI/LO width in bits
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk       input   1      rising-edge clock; single clock domain
//   reset     input   1      synchronous, active-high reset
//   op_valid  input   1      issue strobe for op this cycle
//   op        input   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
//   a         input   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//   b         input   WIDTH  rt operand (multiplier / divisor)
//   req       input   1      CP0 exception request; blocks issue in the same cycle
//   busy      output  1      operation in flight
//   hi        output  WIDTH  HI register (registered)
//   lo        output  WIDTH  LO register (registered)
// BEHAVIOUR
//   - Reset (sync, active-high): hi=0, lo=0, busy=0, countdown=0, pending result cleared. Applies on any edge, including mid-operation; the in-flight op is discarded.
//   - Issue condition: op_valid & ~req & ~busy & ~reset. op_valid while busy or with req=1 is ignored; no state change.
//   - MULT/MULTU at issue edge:
//       - Full 2*WIDTH product computed (signed / unsigned) and latched into pending {phi,plo}.
//       - countdown loaded with MULT_CYCLES; busy=1 from the next cycle.
//   - DIV/DIVU at issue edge: quotient -> plo, remainder -> phi; countdown loaded with DIV_CYCLES.
//   - Countdown: decrements each edge while busy.
//       - On the edge where it goes 1->0: hi<=phi, lo<=plo, busy<=0 in the same edge.
//       - busy is therefore high for exactly N cycles after the issue cycle, and new hi/lo are visible in the first cycle busy=0.
//   - During busy, hi/lo keep their old values; MFHI/MFLO must be stalled by the hazard unit, not by this block.
//   - MTHI/MTLO at issue edge: hi<=a (or lo<=a) directly; busy stays 0; zero-latency.
//   - Reserved op: no effect.
//   - Signed DIV:
//       - quotient truncates toward zero; remainder takes the sign of the dividend.
//       - MIN_INT / -1 gives lo=MIN_INT, hi=0 (wrap, no trap).
//   - Divide by zero (DIV/DIVU with b==0): busy asserts for DIV_CYCLES as normal, but on completion hi and lo keep their previous values.
//   - req while busy: no effect; an issued op is committed and completes.
//   - req only gates issue: an op whose issue cycle has req=1 never starts.
//   - Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//   - No back-to-back overlap: the next op may issue in the first cycle busy=0.
// TESTING
//   - Reset -> hi=lo=0, busy=0. MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   - MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
//   - DIV sign cases (each busy 10 cycles):
//       - DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//       - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//       - DIVU 7/2 -> lo=3, hi=1.
//   - Div by zero: MTHI 0x11, MTLO 0x22, DIVU a=5, b=0 -> busy 10 cycles, then hi=0x11, lo=0x22.
//   - Issue gating:
//       - op_valid=1 with req=1 (MULT 2*3) -> busy stays 0, hi/lo unchanged.
//       - op_valid MTLO 0x55 while busy -> ignored.
//   - Reset asserted at busy cycle 3 of DIV -> next cycle busy=0, hi=lo=0. Then MULT 4*4 issues at once -> lo=0x10 after 5 cycles.

Source files
------------

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle MULT/DIV unit with HI/LO registers, result committed when the countdown expires
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_phi, r_plo;
    logic               r_dz;
    logic               w_issue, w_sgn, w_na, w_nb, w_bz;
    logic [2*WIDTH-1:0] w_ea, w_eb, w_prod;
    logic [WIDTH-1:0]   w_ua, w_ub, w_uq, w_ur, w_quo, w_rem;
    always_comb begin
        w_issue = op_valid & ~req & ~busy & ~reset;
        w_sgn   = ~op[0];
        w_ea    = {{WIDTH{w_sgn & a[WIDTH-1]}}, a};
        w_eb    = {{WIDTH{w_sgn & b[WIDTH-1]}}, b};
        w_prod  = w_ea * w_eb;
        w_na    = w_sgn & a[WIDTH-1];
        w_nb    = w_sgn & b[WIDTH-1];
        w_bz    = b == '0;
        // Divide magnitudes so MIN/-1 wraps naturally; a zero divisor is replaced and its result discarded
        w_ua    = w_na ? -a : a;
        w_ub    = w_bz ? WIDTH'(1) : (w_nb ? -b : b);
        w_uq    = w_ua / w_ub;
        w_ur    = w_ua % w_ub;
        w_quo   = (w_na ^ w_nb) ? -w_uq : w_uq;
        w_rem   = w_na ? -w_ur : w_ur;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_phi <= '0;
            r_plo <= '0;
            r_dz  <= 1'b0;
        end else if (w_issue) begin
            if (op[2:1] == 2'b00) begin
                {r_phi, r_plo} <= w_prod;
                r_cnt          <= CW'(MULT_CYCLES);
                r_dz           <= 1'b0;
            end else if (op[2:1] == 2'b01) begin
                r_phi <= w_rem;
                r_plo <= w_quo;
                r_cnt <= CW'(DIV_CYCLES);
                r_dz  <= w_bz;
            end else if (op == 3'd4) begin
                r_hi <= a;
            end else if (op == 3'd5) begin
                r_lo <= a;
            end
        end else if (busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && !r_dz) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end
    end
    assign busy = r_cnt != '0;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_core.sv
// tb_mdu_core: directed vectors, corner sequences and randomized ops against an arithmetic reference model
module tb_mdu_core;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 1'b0;
    logic        reset, op_valid, req, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] m_hi, m_lo;
    int          errors = 0;
    int          checks = 0;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
        string       name;
    } vec_t;
    vec_t tbl[8];
    mdu_core #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .req(req), .busy(busy), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    // Reference: full-width arithmetic on 64-bit integers, SV division truncates toward zero
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        cyc = 0;
        case (o)
            3'd0: begin sp = sx * sy; {m_hi, m_lo} = sp; cyc = MC; end
            3'd1: begin up = ux * uy; {m_hi, m_lo} = up; cyc = MC; end
            3'd2: begin
                cyc = DC;
                if (y != 0) begin sp = sx / sy; m_lo = sp[31:0]; sp = sx % sy; m_hi = sp[31:0]; end
            end
            3'd3: begin
                cyc = DC;
                if (y != 0) begin up = ux / uy; m_lo = up[31:0]; up = ux % uy; m_hi = up[31:0]; end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask
    // Called at a negedge with busy low; returns at the first negedge where busy is low again
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        op = o; a = x; b = y; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc > 50) begin
                errors++;
                $display("FAIL busy_timeout: got %0d cycles expected <= %0d", cyc, DC);
                break;
            end
        end
    endtask
    initial begin
        int cyc, ecyc;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult_neg"};
        tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, MC, "multu_max"};
        tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_neg"};
        tbl[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, DC, "div_minint"};
        tbl[4] = '{3'd3, 32'd7,        32'd2,          32'h00000001, 32'h00000003, DC, "divu"};
        tbl[5] = '{3'd4, 32'h11,       32'd0,          32'h00000011, 32'h00000003, 0,  "mthi"};
        tbl[6] = '{3'd5, 32'h22,       32'd0,          32'h00000011, 32'h00000022, 0,  "mtlo"};
        tbl[7] = '{3'd3, 32'd5,        32'd0,          32'h00000011, 32'h00000022, DC, "divu_zero"};
        reset = 1'b1; op_valid = 1'b0; req = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
            check({tbl[i].name, "_cyc"}, cyc, tbl[i].ecyc);
            check({tbl[i].name, "_hi"}, hi, tbl[i].ehi);
            check({tbl[i].name, "_lo"}, lo, tbl[i].elo);
        end
        m_hi = hi; m_lo = lo;
        // req blocks issue
        op = 3'd0; a = 32'd2; b = 32'd3; op_valid = 1'b1; req = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0; req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("req_busy", {31'd0, busy}, 32'd0);
        end
        check("req_hi", hi, 32'h11);
        check("req_lo", lo, 32'h22);
        // MTLO while busy is ignored; req while busy does not cancel
        op = 3'd1; a = 32'd4; b = 32'd5; op_valid = 1'b1;
        @(posedge clk);
        #1 op = 3'd5; a = 32'h55; req = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0; req = 1'b0;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (!busy || cyc > 50) break;
            cyc++;
        end
        check("busy_mtlo_cyc", cyc, MC);
        check("busy_mtlo_hi", hi, 32'd0);
        check("busy_mtlo_lo", lo, 32'd20);
        // Reset in the third busy cycle of a DIV
        op = 3'd3; a = 32'd100; b = 32'd7; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        m_hi = 0; m_lo = 0;
        model(3'd0, 32'd4, 32'd4, ecyc);
        do_op(3'd0, 32'd4, 32'd4, cyc);
        check("post_rst_cyc", cyc, ecyc);
        check("post_rst_hi", hi, m_hi);
        check("post_rst_lo", lo, 32'h10);
        // Randomized ops back-to-back against the model
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
            model(ro, ra, rb, ecyc);
            do_op(ro, ra, rb, cyc);
            check($sformatf("rnd%0d_op%0d_cyc", i, ro), cyc, ecyc);
            check($sformatf("rnd%0d_op%0d_hi", i, ro), hi, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, ro), lo, m_lo);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
